// File: rtl/ccl_frame_loader_if.sv
// ccl_frame_loader_if: byte-stream input and buffer-write/status output bundle of the frame loader
interface ccl_frame_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       enb;
  logic [1:0] buf_addr;
  logic [7:0] byte_o;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] err_cnt;
  modport master (
    output in_valid, in_data,
    input  in_ready, enb, buf_addr, byte_o, frame_done, frame_err, err_cnt
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, enb, buf_addr, byte_o, frame_done, frame_err, err_cnt
  );
endinterface

// File: rtl/ccl_frame_loader.sv
// ccl_frame_loader: hunts SYNC_BYTE, writes 4 payload bytes to buffer slots 0..3, then flags the frame
// Define CCL_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the payload.
module ccl_frame_loader #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         TO_W        = 10
) (
  input logic           clk,
  input logic           rst_n,
  ccl_frame_loader_if.slave bus
);
`ifdef CCL_LOADER_CKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DONE} state_t;
  logic [7:0] xor_q, xor_d;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD, DONE} state_t;
`endif
  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            enb_q, enb_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      byte_q, byte_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            acc, in_frame, timeout;
  assign bus.in_ready   = state_q != DONE;
  assign bus.enb        = enb_q;
  assign bus.buf_addr   = addr_q;
  assign bus.byte_o     = byte_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign acc      = bus.in_valid && bus.in_ready;
  assign in_frame = state_q != IDLE && state_q != DONE;
  // an accepted byte in the final cycle of the window beats the timeout
  assign timeout  = in_frame && !acc && cnt_q == TO_W'(TIMEOUT_CYC - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = (in_frame && !acc) ? cnt_q + 1'b1 : '0;
    enb_d   = 1'b0;
    addr_d  = addr_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = timeout;
`ifdef CCL_LOADER_CKSUM_EN
    xor_d   = xor_q;
`endif
    unique case (state_q)
      IDLE: if (acc && bus.in_data == SYNC_BYTE) begin
        state_d = PAYLOAD;
        idx_d   = '0;
`ifdef CCL_LOADER_CKSUM_EN
        xor_d   = '0;
`endif
      end
      PAYLOAD: if (acc) begin
        enb_d  = 1'b1;
        addr_d = idx_q;
        byte_d = bus.in_data;
        idx_d  = idx_q + 1'b1;
`ifdef CCL_LOADER_CKSUM_EN
        xor_d  = xor_q ^ bus.in_data;
        if (idx_q == 2'd3) state_d = CHECK;
`else
        if (idx_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
`endif
      end else if (timeout) state_d = IDLE;
`ifdef CCL_LOADER_CKSUM_EN
      CHECK: if (acc) begin
        done_d = bus.in_data == xor_q;
        err_d  = bus.in_data != xor_q;
        if (done_d) state_d = DONE;
        else state_d = IDLE;
      end else if (timeout) state_d = IDLE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      enb_q     <= 1'b0;
      addr_q    <= '0;
      byte_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef CCL_LOADER_CKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      enb_q     <= enb_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef CCL_LOADER_CKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end
endmodule

// File: tb/tb_ccl_frame_loader.sv
// tb_ccl_frame_loader: randomized frame-level stimulus with a write/result scoreboard for ccl_frame_loader
module tb_ccl_frame_loader;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int T = 16;
  localparam int K_GOOD = 0, K_BAD = 1, K_TMO = 2;
`ifdef CCL_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
  localparam int NPAY = 4;
`else
  localparam bit CK = 1'b0;
  localparam int NPAY = 3;
`endif
  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic err; logic [7:0] cnt; } res_t;
  logic clk = 1'b0;
  logic rst_n;
  ccl_frame_loader_if bus();
  ccl_frame_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(T), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  wr_t  wq[$];
  res_t rq[$];
  wr_t  w;
  res_t r;
  int   n_chk = 0, n_pass = 0, exp_errs = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic int gap(input int g);
    int s;
    if (g >= 0) return g;
    s = int'($urandom_range(0, 3));
    return s == 0 ? 0 : s == 3 ? T - 1 : int'($urandom_range(0, 3));
  endfunction
  task automatic send(input logic [7:0] b, input int g);
    int guard = 0;
    repeat (g) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("in_ready_stuck", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic junk();
    logic [7:0] b;
    do b = 8'($urandom); while (b == SYNC);
    send(b, gap(-1));
  endtask
  task automatic expect_err();
    exp_errs = exp_errs < 255 ? exp_errs + 1 : 255;
    rq.push_back(res_t'{1'b1, 8'(exp_errs)});
  endtask
  task automatic do_frame(input logic [7:0] p0, p1, p2, p3, input int kind, input int k, input int g);
    logic [7:0] p[4];
    logic [7:0] x;
    p = '{p0, p1, p2, p3};
    x = p0 ^ p1 ^ p2 ^ p3;
    send(SYNC, gap(g));
    if (kind == K_TMO) begin
      for (int i = 0; i < k; i++) begin
        wq.push_back(wr_t'{2'(i), p[i]});
        send(p[i], gap(g));
      end
      expect_err();
      repeat (T + 1) @(negedge clk);
    end else begin
      for (int i = 0; i < 4; i++) begin
        wq.push_back(wr_t'{2'(i), p[i]});
        if (!CK && i == 3) rq.push_back(res_t'{1'b0, 8'(exp_errs)});
        send(p[i], gap(g));
      end
      if (CK && kind == K_GOOD) begin
        rq.push_back(res_t'{1'b0, 8'(exp_errs)});
        send(x, gap(g));
      end else if (CK) begin
        expect_err();
        send(x ^ 8'($urandom_range(1, 255)), gap(g));
      end
    end
  endtask
  function automatic logic [7:0] rb();
    return $urandom_range(0, 3) == 0 ? SYNC : 8'($urandom);
  endfunction
  always @(negedge clk) if (rst_n) begin
    if (bus.enb) begin
      if (wq.size() == 0) chk("spurious_write", 1, 0);
      else begin
        w = wq.pop_front();
        chk("buf_addr", 32'(bus.buf_addr), 32'(w.a));
        chk("byte_o", 32'(bus.byte_o), 32'(w.d));
      end
    end
    if (bus.frame_done || bus.frame_err) begin
      chk("pulse_exclusive", 32'(bus.frame_done & bus.frame_err), 0);
      if (rq.size() == 0) chk("spurious_pulse", 1, 0);
      else begin
        r = rq.pop_front();
        chk("frame_err", 32'(bus.frame_err), 32'(r.err));
        chk("err_cnt", 32'(bus.err_cnt), 32'(r.cnt));
      end
      if (bus.frame_done) chk("in_ready_done", 32'(bus.in_ready), 0);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #3;
    chk("reset_outputs", 32'({bus.in_ready, bus.enb, bus.buf_addr, bus.byte_o, bus.frame_done, bus.frame_err, bus.err_cnt}), 32'h200000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(8'h11, 8'h22, 8'h33, 8'h44, K_GOOD, 4, 0);
    if (CK) do_frame(8'h11, 8'h22, 8'h33, 8'h44, K_BAD, 4, 0);
    send(8'h00, 0);
    send(8'h7F, 0);
    do_frame(SYNC, 8'h01, 8'h02, 8'h03, K_GOOD, 4, 0);
    do_frame(8'h11, 8'h22, 8'h33, 8'h44, K_TMO, 1, 0);
    do_frame(rb(), rb(), rb(), rb(), K_GOOD, 4, 0);
    do_frame(rb(), rb(), rb(), rb(), K_GOOD, 4, T - 1);
    do_frame(rb(), rb(), rb(), rb(), K_TMO, NPAY, T - 1);
    send(SYNC, 0);
    wq.push_back(wr_t'{2'd0, 8'h5A});
    send(8'h5A, 0);
    wq.push_back(wr_t'{2'd1, 8'h3C});
    send(8'h3C, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({bus.in_ready, bus.enb, bus.buf_addr, bus.byte_o, bus.frame_done, bus.frame_err, bus.err_cnt}), 32'h200000);
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(8'h01, 8'h02, 8'h03, 8'h04, K_GOOD, 4, 0);
    for (int n = 0; n < 150; n++) begin
      int kind;
      repeat ($urandom_range(0, 2)) junk();
      kind = int'($urandom_range(0, 2));
      if (!CK && kind == K_BAD) kind = K_GOOD;
      do_frame(rb(), rb(), rb(), rb(), kind, int'($urandom_range(0, NPAY)), -1);
    end
    for (int n = 0; n < 260; n++) do_frame(8'h00, 8'h00, 8'h00, 8'h00, K_TMO, 0, 0);
    do_frame(rb(), rb(), rb(), rb(), K_GOOD, 4, -1);
    do_frame(rb(), rb(), rb(), rb(), K_TMO, 2, -1);
    repeat (T + 4) @(negedge clk);
    chk("writes_drained", 32'(wq.size()), 0);
    chk("results_drained", 32'(rq.size()), 0);
    chk("err_cnt_saturated", 32'(bus.err_cnt), 32'hFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
